// File: rtl/forex_update_ctrl.sv
// Avalon-MM front end for the forex graph engine: stages edge updates in a FIFO,
// drains them to the engine on start, then runs the engine and reports completion.
module forex_update_ctrl #(
    parameter int NODE_W   = 6,
    parameter int WEIGHT_W = 32,
    parameter int DEPTH    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [2:0]          address,
    input  logic [WEIGHT_W-1:0] writedata,
    output logic [WEIGHT_W-1:0] readdata,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [NODE_W-1:0]   upd_src,
    output logic [NODE_W-1:0]   upd_dst,
    output logic [WEIGHT_W-1:0] upd_w,
    output logic                eng_start,
    input  logic                eng_done,
    output logic                irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * NODE_W + WEIGHT_W;

    localparam logic [AW-1:0]       PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]       PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]       CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]       FULL_CNT = CW'(DEPTH);
    localparam logic [WEIGHT_W-1:0] W_ZERO   = {WEIGHT_W{1'b0}};
    localparam logic [WEIGHT_W-1:0] W_ONE    = WEIGHT_W'(1);
    localparam logic [NODE_W-1:0]   N_ZERO   = {NODE_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [NODE_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic                done_q, done_d, ovf_q, ovf_d;
    logic [WEIGHT_W-1:0] run_cnt_q, run_cnt_d;
    logic [WEIGHT_W-1:0] readdata_q, readdata_d;
    logic                upd_valid_q, upd_valid_d;
    logic [NODE_W-1:0]   upd_src_q, upd_src_d, upd_dst_q, upd_dst_d;
    logic [WEIGHT_W-1:0] upd_w_q, upd_w_d;
    logic                eng_start_q, eng_start_d;

    logic                wr_en_s, rd_en_s, push_s, ctrl_s;
    logic                start_s, clear_s, flush_s;
    logic                full_s, empty_s, pop_s, push_ok_s, drop_s;
    logic [EW-1:0]       push_entry_s, head_s;
    logic [WEIGHT_W-1:0] status_s;

    assign wr_en_s      = chipselect && write;
    assign rd_en_s      = chipselect && read;
    assign push_s       = wr_en_s && (address == 3'd1);
    assign ctrl_s       = wr_en_s && (address == 3'd2);
    assign start_s      = ctrl_s && writedata[0];
    assign clear_s      = ctrl_s && writedata[1];
    assign flush_s      = ctrl_s && writedata[2];
    assign full_s       = (count_q == FULL_CNT);
    assign empty_s      = (count_q == CNT_ZERO);
    assign pop_s        = upd_valid_q && upd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s    = push_s && (!full_s || pop_s);
    assign drop_s       = push_s && full_s && !pop_s;
    assign push_entry_s = {src_q, dst_q, writedata};

    // Next-state logic for FIFO, staging, stickies, FSM, update beat and readback.
    always_comb begin
        if (flush_s) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_d = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        if (wr_en_s && (address == 3'd0)) begin
            src_d = writedata[2*NODE_W-1:NODE_W];
            dst_d = writedata[NODE_W-1:0];
        end else begin
            src_d = src_q;
            dst_d = dst_q;
        end

        done_d    = (state_q == S_DONE) || (done_q && !clear_s);
        ovf_d     = drop_s || (ovf_q && !clear_s);
        run_cnt_d = (state_q == S_DONE) ? run_cnt_q + W_ONE : run_cnt_q;

        eng_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_s) state_d = S_DRAIN;
                else         state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (empty_s) begin
                    state_d     = S_RUN;
                    eng_start_d = 1'b1;
                end else begin
                    state_d     = S_DRAIN;
                end
            end
            S_RUN: begin
                if (eng_done) state_d = S_DONE;
                else          state_d = S_RUN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The head is the entry being written when the FIFO is otherwise empty next cycle.
        if (push_ok_s && (wr_ptr_q == rd_ptr_d)) head_s = push_entry_s;
        else                                     head_s = mem_q[rd_ptr_d];

        upd_valid_d = (state_d == S_DRAIN) && (count_d != CNT_ZERO);
        if (upd_valid_d) begin
            upd_src_d = head_s[EW-1 -: NODE_W];
            upd_dst_d = head_s[WEIGHT_W +: NODE_W];
            upd_w_d   = head_s[WEIGHT_W-1:0];
        end else begin
            upd_src_d = N_ZERO;
            upd_dst_d = N_ZERO;
            upd_w_d   = W_ZERO;
        end

        status_s       = W_ZERO;
        status_s[0]    = (state_q != S_IDLE);
        status_s[1]    = done_q;
        status_s[2]    = full_s;
        status_s[3]    = empty_s;
        status_s[4]    = ovf_q;
        status_s[15:8] = 8'(count_q);

        if (rd_en_s) begin
            case (address)
                3'd3:    readdata_d = status_s;
                3'd4:    readdata_d = run_cnt_q;
                default: readdata_d = W_ZERO;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= push_entry_s;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            src_q       <= N_ZERO;
            dst_q       <= N_ZERO;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            run_cnt_q   <= W_ZERO;
            readdata_q  <= W_ZERO;
            upd_valid_q <= 1'b0;
            upd_src_q   <= N_ZERO;
            upd_dst_q   <= N_ZERO;
            upd_w_q     <= W_ZERO;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            run_cnt_q   <= run_cnt_d;
            readdata_q  <= readdata_d;
            upd_valid_q <= upd_valid_d;
            upd_src_q   <= upd_src_d;
            upd_dst_q   <= upd_dst_d;
            upd_w_q     <= upd_w_d;
            eng_start_q <= eng_start_d;
        end
    end

    assign readdata  = readdata_q;
    assign upd_valid = upd_valid_q;
    assign upd_src   = upd_src_q;
    assign upd_dst   = upd_dst_q;
    assign upd_w     = upd_w_q;
    assign eng_start = eng_start_q;
    assign irq       = done_q;

endmodule

// File: tb/tb_forex_update_ctrl.sv
// Bench for forex_update_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the register/FIFO/run behaviour.
module tb_forex_update_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        upd_valid, upd_ready = 1'b0;
    logic [5:0]  upd_src, upd_dst;
    logic [31:0] upd_w;
    logic        eng_start, eng_done = 1'b0, irq;

    forex_update_ctrl dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_src(upd_src),
        .upd_dst(upd_dst), .upd_w(upd_w), .eng_start(eng_start),
        .eng_done(eng_done), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  s;
        logic [5:0]  d;
        logic [31:0] w;
    } ent_t;

    // Reference model: phase 0 idle, 1 draining, 2 engine running, 3 done.
    ent_t        q[$];
    int          m_phase;
    logic        m_done, m_ovf, m_start;
    logic [31:0] m_runs, m_rd;
    logic [5:0]  m_src, m_dst;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic cs, input logic wr, input logic rd, input logic [2:0] a,
                        input logic [31:0] wd, input logic rdy, input logic edn, input logic rst);
        int   sz0;
        logic pop;
        logic is_full;
        logic exp_v;
        ent_t e;
        chipselect = cs; write = wr; read = rd; address = a; writedata = wd;
        upd_ready = rdy; eng_done = edn; reset = rst;
        if (rst) begin
            q.delete();
            m_phase = 0; m_done = 1'b0; m_ovf = 1'b0; m_start = 1'b0;
            m_runs = 32'd0; m_rd = 32'd0; m_src = 6'd0; m_dst = 6'd0;
        end else begin
            sz0     = q.size();
            is_full = (sz0 == DEPTH);
            pop     = (m_phase == 1) && (sz0 > 0) && rdy;
            if (cs && rd) begin
                if (a == 3'd3)
                    m_rd = {16'd0, 8'(sz0), 3'b000, m_ovf, (sz0 == 0), is_full,
                            m_done, (m_phase != 0)};
                else if (a == 3'd4)
                    m_rd = m_runs;
                else
                    m_rd = 32'd0;
            end
            if (pop) void'(q.pop_front());
            if (cs && wr && a == 3'd1) begin
                if (is_full && !pop) begin
                    m_ovf = 1'b1;
                end else begin
                    e.s = m_src; e.d = m_dst; e.w = wd;
                    q.push_back(e);
                end
            end
            if (cs && wr && a == 3'd0) begin
                m_src = wd[11:6];
                m_dst = wd[5:0];
            end
            if (cs && wr && a == 3'd2) begin
                if (wd[1]) begin m_done = 1'b0; m_ovf = 1'b0; end
                if (wd[2]) q.delete();
            end
            m_start = 1'b0;
            case (m_phase)
                0: if (cs && wr && a == 3'd2 && wd[0]) m_phase = 1;
                1: if (sz0 == 0) begin m_phase = 2; m_start = 1'b1; end
                2: if (edn) m_phase = 3;
                default: begin m_phase = 0; m_done = 1'b1; m_runs = m_runs + 32'd1; end
            endcase
        end
        @(posedge clk);
        #1;
        exp_v = (m_phase == 1) && (q.size() > 0);
        check_eq("upd_valid", upd_valid, exp_v);
        if (exp_v) begin
            check_eq("upd_src", upd_src, q[0].s);
            check_eq("upd_dst", upd_dst, q[0].d);
            check_eq("upd_w", upd_w, q[0].w);
        end
        check_eq("eng_start", eng_start, m_start);
        check_eq("irq", irq, m_done);
        check_eq("readdata", readdata, m_rd);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic rdy);
        step(1'b1, 1'b1, 1'b0, a, d, rdy, 1'b0, 1'b0);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        step(1'b1, 1'b0, 1'b1, a, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic end_run();
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
    endtask

    task automatic finish_run();
        int k;
        k = 0;
        while (eng_start !== 1'b1 && k < 64) begin
            idle(1, 1'b1);
            k++;
        end
        check_eq("start_seen", eng_start, 1'b1);
        end_run();
    endtask

    initial begin
        logic [31:0] r, wd;
        logic [2:0]  a;

        do_reset();
        check_eq("rst_valid", upd_valid, 1'b0);
        rd_reg(3'd3);
        check_eq("rst_status", readdata, 32'h0000_0008);

        // Single update end to end.
        wr_reg(3'd0, 32'h0000_0083, 1'b1);
        wr_reg(3'd1, 32'd100, 1'b1);
        wr_reg(3'd2, 32'd1, 1'b1);
        check_eq("beat_src", upd_src, 6'd2);
        check_eq("beat_w", upd_w, 32'd100);
        finish_run();
        check_eq("irq_set", irq, 1'b1);
        rd_reg(3'd4);
        check_eq("run_cnt1", readdata, 32'd1);

        // Start with an empty FIFO.
        do_reset();
        wr_reg(3'd2, 32'd1, 1'b1);
        idle(1, 1'b1);
        check_eq("empty_start_lat", eng_start, 1'b1);
        end_run();

        // Overflow and sticky clear.
        do_reset();
        wr_reg(3'd0, 32'h0000_0145, 1'b0);
        for (int i = 0; i <= DEPTH; i++) wr_reg(3'd1, 32'h1000 + 32'(i), 1'b0);
        rd_reg(3'd3);
        check_eq("ovf_status", readdata, 32'h0000_1014);
        wr_reg(3'd2, 32'd2, 1'b0);
        rd_reg(3'd3);
        check_eq("clr_status", readdata, 32'h0000_1004);
        wr_reg(3'd2, 32'd4, 1'b0);

        // Back-pressure during drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_reg(3'd0, {20'd0, 6'(i + 7), 6'(40 - i)}, 1'b0);
            wr_reg(3'd1, 32'hA000 + 32'(i), 1'b0);
        end
        wr_reg(3'd2, 32'd1, 1'b0);
        idle(5, 1'b0);
        check_eq("bp_head_w", upd_w, 32'hA000);
        finish_run();

        // Flush mid-drain.
        do_reset();
        for (int i = 0; i < 5; i++) wr_reg(3'd1, 32'h5000 + 32'(i), 1'b0);
        wr_reg(3'd2, 32'd1, 1'b0);
        idle(2, 1'b1);
        wr_reg(3'd2, 32'd4, 1'b0);
        check_eq("flush_valid", upd_valid, 1'b0);
        idle(1, 1'b0);
        check_eq("flush_run", eng_start, 1'b1);
        rd_reg(3'd3);
        check_eq("flush_status", readdata, 32'h0000_0009);
        end_run();

        // Reset while running, then a normal run.
        do_reset();
        wr_reg(3'd1, 32'd11, 1'b1);
        wr_reg(3'd1, 32'd12, 1'b1);
        wr_reg(3'd2, 32'd1, 1'b1);
        for (int k = 0; k < 64 && eng_start !== 1'b1; k++) idle(1, 1'b1);
        check_eq("run_reached", eng_start, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        check_eq("rr_start", eng_start, 1'b0);
        check_eq("rr_irq", irq, 1'b0);
        rd_reg(3'd3);
        check_eq("rr_status", readdata, 32'h0000_0008);
        wr_reg(3'd1, 32'd13, 1'b1);
        wr_reg(3'd2, 32'd1, 1'b1);
        finish_run();
        rd_reg(3'd4);
        check_eq("rr_runs", readdata, 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      a = 3'd0;
            else if (r < 50) a = 3'd1;
            else if (r < 58) a = 3'd2;
            else if (r < 75) a = 3'd3;
            else if (r < 88) a = 3'd4;
            else             a = 3'($urandom_range(5, 7));
            wd = $urandom;
            if (a == 3'd2) wd = {29'd0, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
            step($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), a, wd,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 999) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
